// File: rtl/scandoubler_ctrl_if.sv
// Request/sync inputs and pixel-strobe/status outputs of the scandoubler controller.
// The master drives requests and source syncs; the slave is the controller itself.
interface scandoubler_ctrl_if;
  logic [1:0] mode_req;
  logic       hq2x_req;
  logic       mono_req;
  logic       hs_in;
  logic       vs_in;
  logic       ce_pix;
  logic       ce_pix_actual;
  logic       line_start;
  logic       hq2x;
  logic       mono;
  logic [1:0] mode_act;
  logic       busy;

  modport master (
    output mode_req, hq2x_req, mono_req, hs_in, vs_in,
    input  ce_pix, ce_pix_actual, line_start, hq2x, mono, mode_act, busy
  );

  modport slave (
    input  mode_req, hq2x_req, mono_req, hs_in, vs_in,
    output ce_pix, ce_pix_actual, line_start, hq2x, mono, mode_act, busy
  );
endinterface

// File: rtl/scandoubler_ctrl.sv
// Pixel-enable divider and mode-switch controller; strobes are 1 clk_sys wide, no backpressure.
// SD_CTRL_SAFE_SWITCH_EN: switch at vsync rise and drain DRAIN_CE strobes; else switch at next phase 0.
module scandoubler_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DRAIN_CE = 8
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  scandoubler_ctrl_if.slave  sd
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("scandoubler_ctrl: CLK_DIV out of range 2..255");
  end
  if (DRAIN_CE < 1 || DRAIN_CE > 255) begin : g_bad_drain_ce
    $error("scandoubler_ctrl: DRAIN_CE out of range 1..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [7:0] div_nxt;
  logic       ce_q;
  logic [1:0] phase;
  logic [1:0] phase_last;
  logic [1:0] phase_nxt;
  logic       hs_q;
  logic [1:0] mode_q;
  logic       hq2x_q;
  logic       mono_q;
  logic       req_diff;
  logic       gate_actual;
  logic       busy_w;

  assign div_nxt = (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;

  // ce_pix is registered so it is high exactly while the divider sits at CLK_DIV-1
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 8'd0;
      ce_q    <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      ce_q    <= (div_nxt == DIV_LAST);
      if (ce_q) begin
        hs_q <= sd.hs_in;
      end
    end
  end

  // Mode 3 is reserved and behaves as 1:1
  always_comb begin
    phase_last = 2'd0;
    case (mode_q)
      2'd1:    phase_last = 2'd1;
      2'd2:    phase_last = 2'd3;
      default: phase_last = 2'd0;
    endcase
  end

  assign phase_nxt = (phase == phase_last) ? 2'd0 : phase + 2'd1;
  assign req_diff  = {sd.mode_req, sd.hq2x_req, sd.mono_req} != {mode_q, hq2x_q, mono_q};

`ifdef SD_CTRL_SAFE_SWITCH_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CE);

  state_t     state;
  logic [7:0] drain_cnt;
  logic       vs_q;
  logic       vs_rise;

  assign vs_rise = ce_q & sd.vs_in & ~vs_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
    end else if (ce_q) begin
      vs_q <= sd.vs_in;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      drain_cnt <= 8'd0;
      phase     <= 2'd0;
      mode_q    <= 2'd0;
      hq2x_q    <= 1'b0;
      mono_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ce_q) begin
            phase <= phase_nxt;
          end
          if (req_diff) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!req_diff) begin
            state <= ST_RUN;
            if (ce_q) begin
              phase <= phase_nxt;
            end
          end else if (vs_rise) begin
            mode_q    <= sd.mode_req;
            hq2x_q    <= sd.hq2x_req;
            mono_q    <= sd.mono_req;
            phase     <= 2'd0;
            drain_cnt <= DRAIN_LD;
            state     <= ST_DRAIN;
          end else if (ce_q) begin
            phase <= phase_nxt;
          end
        end
        ST_DRAIN: begin
          // Phase is pinned at 0 so the first strobe back in RUN starts a pixel
          phase <= 2'd0;
          if (ce_q) begin
            drain_cnt <= drain_cnt - 8'd1;
            if (drain_cnt == 8'd1) begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state <= ST_RUN;
          phase <= 2'd0;
        end
      endcase
    end
  end

  assign gate_actual = (state == ST_DRAIN);
  assign busy_w      = (state != ST_RUN);
`else
  // Apply a new request only on a pixel boundary so no source pixel is split
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= 2'd0;
      mode_q <= 2'd0;
      hq2x_q <= 1'b0;
      mono_q <= 1'b0;
    end else if (ce_q) begin
      if (req_diff && (phase == 2'd0)) begin
        mode_q <= sd.mode_req;
        hq2x_q <= sd.hq2x_req;
        mono_q <= sd.mono_req;
        phase  <= 2'd0;
      end else begin
        phase <= phase_nxt;
      end
    end
  end

  assign gate_actual = 1'b0;
  assign busy_w      = 1'b0;
`endif

  assign sd.ce_pix        = ce_q;
  assign sd.ce_pix_actual = ce_q & (phase == 2'd0) & ~gate_actual;
  assign sd.line_start    = ce_q & hs_q & ~sd.hs_in;
  assign sd.mode_act      = mode_q;
  assign sd.hq2x          = hq2x_q;
  assign sd.mono          = mono_q;
  assign sd.busy          = busy_w;

endmodule
